// File: rtl/reg_file_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_cmd_ctrl_pkg
//   Shared definitions for the UART command controller that fronts the system
//   register file.
//   - CMD_WRITE / CMD_READ : default opcode bytes for write and read frames
//   - state_e              : command-parser state encoding
// -----------------------------------------------------------------------------
package reg_file_cmd_ctrl_pkg;

  // Default opcodes.
  //   Write frame: CMD_WRITE, addr, data
  //   Read frame : CMD_READ, addr
  localparam logic [7:0] CMD_WRITE = 8'hAA;
  localparam logic [7:0] CMD_READ  = 8'hBB;

  // Parser states.
  //   WR_ADDR / RD_ADDR : waiting for the address byte
  //   WR_DATA           : waiting for the write data byte
  //   RD_WAIT           : read strobe issued, waiting for register file data
  //   TX_SEND           : read data captured, waiting for the TX path to free up
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

endpackage : reg_file_cmd_ctrl_pkg

// File: rtl/reg_file_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_cmd_ctrl
//   Decodes byte commands arriving from the UART receiver and turns them into
//   register file write/read strobes. Read results are returned to the UART
//   transmitter. This block is the only driver of the register file's
//   address/strobe/write-data inputs.
//
// Ports
//   clk                 in   system clock
//   reset               in   asynchronous, active-low reset
//   rx_data             in   received byte
//   rx_data_valid       in   1-cycle pulse, rx_data valid
//   rf_address          out  register file address (held between frames)
//   rf_write_enable     out  1-cycle write strobe
//   rf_write_data       out  write data
//   rf_read_enable      out  1-cycle read strobe
//   rf_read_data        in   read data from the register file
//   rf_read_data_valid  in   1-cycle qualifier for rf_read_data
//   tx_data             out  byte to transmit
//   tx_data_valid       out  1-cycle pulse, tx_data valid
//   tx_busy             in   TX path busy
//   cmd_error           out  1-cycle pulse: bad opcode, bad address or dropped byte
//
// All outputs are registered. The FSM is split into a state register, a
// next-state process and a process that computes the next value of every
// registered output; one more flop process holds those outputs.
// -----------------------------------------------------------------------------
module reg_file_cmd_ctrl
  import reg_file_cmd_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDRESS_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD        = CMD_WRITE,
  parameter logic [DATA_WIDTH-1:0] RD_CMD        = CMD_READ
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_data_valid,
  output logic [ADDRESS_WIDTH-1:0] rf_address,
  output logic                     rf_write_enable,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  output logic                     rf_read_enable,
  input  logic [DATA_WIDTH-1:0]    rf_read_data,
  input  logic                     rf_read_data_valid,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_busy,
  output logic                     cmd_error
);

  // An address byte is legal only if every bit above the address field is zero.
  function automatic logic addr_in_range(input logic [DATA_WIDTH-1:0] b);
    return (b >> ADDRESS_WIDTH) == {DATA_WIDTH{1'b0}};
  endfunction

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] rf_address_q, rf_address_d;
  logic                     rf_write_enable_q, rf_write_enable_d;
  logic [DATA_WIDTH-1:0]    rf_write_data_q, rf_write_data_d;
  logic                     rf_read_enable_q, rf_read_enable_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     tx_data_valid_q, tx_data_valid_d;
  logic                     cmd_error_q, cmd_error_d;

  logic                     addr_ok;

  assign addr_ok = addr_in_range(rx_data);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Advances only on an rx byte or a read/TX handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_data_valid) begin
          if (rx_data == WR_CMD) begin
            state_d = ST_WR_ADDR;
          end else if (rx_data == RD_CMD) begin
            state_d = ST_RD_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (rx_data_valid) begin
          state_d = addr_ok ? ST_WR_DATA : ST_IDLE;
        end else begin
          state_d = ST_WR_ADDR;
        end
      end
      ST_WR_DATA: begin
        if (rx_data_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_RD_ADDR: begin
        if (rx_data_valid) begin
          state_d = addr_ok ? ST_RD_WAIT : ST_IDLE;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_WAIT: begin
        // If TX is free when the data arrives, the byte goes out straight away
        // and TX_SEND is skipped.
        if (rf_read_data_valid) begin
          state_d = tx_busy ? ST_TX_SEND : ST_IDLE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_TX_SEND: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TX_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. Computes the next value of every registered output.
  always_comb begin
    rf_address_d      = rf_address_q;
    rf_write_data_d   = rf_write_data_q;
    tx_data_d         = tx_data_q;
    rf_write_enable_d = 1'b0;
    rf_read_enable_d  = 1'b0;
    tx_data_valid_d   = 1'b0;
    cmd_error_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_data_valid && (rx_data != WR_CMD) && (rx_data != RD_CMD)) begin
          cmd_error_d = 1'b1;
        end else begin
          cmd_error_d = 1'b0;
        end
      end
      ST_WR_ADDR, ST_RD_ADDR: begin
        if (rx_data_valid) begin
          if (addr_ok) begin
            rf_address_d     = rx_data[ADDRESS_WIDTH-1:0];
            rf_read_enable_d = (state_q == ST_RD_ADDR);
          end else begin
            cmd_error_d = 1'b1;
          end
        end else begin
          cmd_error_d = 1'b0;
        end
      end
      ST_WR_DATA: begin
        if (rx_data_valid) begin
          rf_write_data_d   = rx_data;
          rf_write_enable_d = 1'b1;
        end else begin
          rf_write_enable_d = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        // A byte that arrives while a read is in progress is dropped and flagged.
        cmd_error_d = rx_data_valid;
        if (rf_read_data_valid) begin
          tx_data_d       = rf_read_data;
          tx_data_valid_d = !tx_busy;
        end else begin
          tx_data_valid_d = 1'b0;
        end
      end
      ST_TX_SEND: begin
        cmd_error_d     = rx_data_valid;
        tx_data_valid_d = !tx_busy;
      end
      default: begin
        cmd_error_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_address_q      <= {ADDRESS_WIDTH{1'b0}};
      rf_write_enable_q <= 1'b0;
      rf_write_data_q   <= {DATA_WIDTH{1'b0}};
      rf_read_enable_q  <= 1'b0;
      tx_data_q         <= {DATA_WIDTH{1'b0}};
      tx_data_valid_q   <= 1'b0;
      cmd_error_q       <= 1'b0;
    end else begin
      rf_address_q      <= rf_address_d;
      rf_write_enable_q <= rf_write_enable_d;
      rf_write_data_q   <= rf_write_data_d;
      rf_read_enable_q  <= rf_read_enable_d;
      tx_data_q         <= tx_data_d;
      tx_data_valid_q   <= tx_data_valid_d;
      cmd_error_q       <= cmd_error_d;
    end
  end

  assign rf_address      = rf_address_q;
  assign rf_write_enable = rf_write_enable_q;
  assign rf_write_data   = rf_write_data_q;
  assign rf_read_enable  = rf_read_enable_q;
  assign tx_data         = tx_data_q;
  assign tx_data_valid   = tx_data_valid_q;
  assign cmd_error       = cmd_error_q;

endmodule : reg_file_cmd_ctrl

// File: tb/tb_reg_file_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_file_cmd_ctrl
//   Self-checking bench. A frame-level reference model predicts every
//   registered output cycle by cycle. A small register file model answers read
//   strobes one cycle later. Directed scenarios are followed by a randomized
//   byte stream with a randomly toggling tx_busy.
// -----------------------------------------------------------------------------
module tb_reg_file_cmd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] rx_data;
  logic          rx_data_valid;
  logic [AW-1:0] rf_address;
  logic          rf_write_enable;
  logic [DW-1:0] rf_write_data;
  logic          rf_read_enable;
  logic [DW-1:0] rf_read_data;
  logic          rf_read_data_valid;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid;
  logic          tx_busy;
  logic          cmd_error;

  always #5 clk = ~clk;

  reg_file_cmd_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .WR_CMD        (8'hAA),
    .RD_CMD        (8'hBB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .rx_data            (rx_data),
    .rx_data_valid      (rx_data_valid),
    .rf_address         (rf_address),
    .rf_write_enable    (rf_write_enable),
    .rf_write_data      (rf_write_data),
    .rf_read_enable     (rf_read_enable),
    .rf_read_data       (rf_read_data),
    .rf_read_data_valid (rf_read_data_valid),
    .tx_data            (tx_data),
    .tx_data_valid      (tx_data_valid),
    .tx_busy            (tx_busy),
    .cmd_error          (cmd_error)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0] frame[$];   // bytes of the frame accepted so far
  bit         awaiting;   // read strobe issued, data not yet returned
  bit         tx_hold;    // read data captured, TX still busy
  logic [3:0] exp_addr;
  logic [7:0] exp_wdata, exp_txd;
  bit         exp_we, exp_re, exp_txv, exp_err;

  function automatic void model_reset();
    frame.delete();
    awaiting  = 1'b0;
    tx_hold   = 1'b0;
    exp_addr  = 4'h0;
    exp_wdata = 8'h00;
    exp_txd   = 8'h00;
    exp_we    = 1'b0;
    exp_re    = 1'b0;
    exp_txv   = 1'b0;
    exp_err   = 1'b0;
  endfunction

  function automatic void model_step(bit rxv, logic [7:0] rx, bit busy, bit rv, logic [7:0] rd);
    exp_we  = 1'b0;
    exp_re  = 1'b0;
    exp_txv = 1'b0;
    exp_err = 1'b0;
    if (awaiting || tx_hold) begin
      if (rxv) exp_err = 1'b1;
      if (awaiting && rv) begin
        exp_txd  = rd;
        awaiting = 1'b0;
        if (busy) tx_hold = 1'b1;
        else      exp_txv = 1'b1;
      end else if (tx_hold && !busy) begin
        exp_txv = 1'b1;
        tx_hold = 1'b0;
      end
    end else if (rxv) begin
      if (frame.size() == 0) begin
        if (rx == 8'hAA || rx == 8'hBB) frame.push_back(rx);
        else exp_err = 1'b1;
      end else if (frame.size() == 1) begin
        if (rx > 8'd15) begin
          exp_err = 1'b1;
          frame.delete();
        end else begin
          exp_addr = rx[3:0];
          if (frame[0] == 8'hBB) begin
            exp_re   = 1'b1;
            awaiting = 1'b1;
            frame.delete();
          end else begin
            frame.push_back(rx);
          end
        end
      end else begin
        exp_we    = 1'b1;
        exp_wdata = rx;
        frame.delete();
      end
    end
  endfunction

  // ---------------- register file model and bookkeeping ----------------
  logic [7:0] mem [16];
  bit         rf_pend;
  logic [3:0] rf_pend_addr;
  bit         spur_en = 1'b0;
  int         cyc = 0;
  int         we_cnt = 0, re_cnt = 0, txv_cnt = 0, err_cnt = 0;
  int         last_re_cyc = 0, last_txv_cyc = 0;
  logic [7:0] last_tx = 8'h00;

  // One clock cycle: check outputs mid-cycle, then drive this cycle's inputs.
  task automatic tick(input bit rxv, input logic [7:0] rx, input bit busy);
    @(negedge clk);
    cyc++;
    chk("rf_address", 32'(rf_address),      32'(exp_addr));
    chk("rf_we",      32'(rf_write_enable), 32'(exp_we));
    chk("rf_re",      32'(rf_read_enable),  32'(exp_re));
    chk("tx_valid",   32'(tx_data_valid),   32'(exp_txv));
    chk("cmd_error",  32'(cmd_error),       32'(exp_err));
    if (exp_we)  chk("rf_wdata", 32'(rf_write_data), 32'(exp_wdata));
    if (exp_txv) chk("tx_data",  32'(tx_data),       32'(exp_txd));
    if (rf_write_enable && rf_read_enable) chk("we_re_overlap", 32'(1), 32'(0));
    if (tx_data_valid && tx_busy)          chk("tx_while_busy", 32'(1), 32'(0));
    if (rf_write_enable) begin we_cnt++; mem[rf_address] = rf_write_data; end
    if (rf_read_enable)  begin re_cnt++; last_re_cyc = cyc; end
    if (tx_data_valid)   begin txv_cnt++; last_txv_cyc = cyc; last_tx = tx_data; end
    if (cmd_error)       err_cnt++;
    rf_read_data_valid = rf_pend;
    rf_read_data       = rf_pend ? mem[rf_pend_addr] : 8'($urandom);
    if (!rf_pend && !awaiting && spur_en && ($urandom_range(0, 15) == 0))
      rf_read_data_valid = 1'b1;
    rf_pend      = rf_read_enable;
    rf_pend_addr = rf_address;
    rx_data_valid = rxv;
    rx_data       = rx;
    tx_busy       = busy;
    if (reset) model_step(rxv, rx, busy, rf_read_data_valid, rf_read_data);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset              = 1'b0;
    rx_data_valid      = 1'b0;
    rx_data            = 8'h00;
    tx_busy            = 1'b0;
    rf_read_data_valid = 1'b0;
    rf_pend            = 1'b0;
    model_reset();
    repeat (n) tick(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2: return 8'hAA;
      3, 4, 5: return 8'hBB;
      6, 7, 8: return 8'($urandom_range(0, 15));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  int n_addr, we0, err0, txv0, fall_cyc;
  bit busy_r;

  initial begin
    reset              = 1'b0;
    rx_data            = 8'h00;
    rx_data_valid      = 1'b0;
    tx_busy            = 1'b0;
    rf_read_data       = 8'h00;
    rf_read_data_valid = 1'b0;
    rf_pend            = 1'b0;
    rf_pend_addr       = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    model_reset();
    do_reset(3);

    // 1: write 3C to address 5
    we0 = we_cnt; err0 = err_cnt;
    tick(1'b1, 8'hAA, 1'b0);
    tick(1'b1, 8'h05, 1'b0);
    tick(1'b1, 8'h3C, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    chk("t1_we_count", 32'(we_cnt - we0), 32'(1));
    chk("t1_no_error", 32'(err_cnt - err0), 32'(0));
    chk("t1_mem5", 32'(mem[5]), 32'(8'h3C));

    // 2: read address 5 back, TX free
    tick(1'b1, 8'hBB, 1'b0);
    tick(1'b1, 8'h05, 1'b0);
    n_addr = cyc;
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    chk("t2_re_latency", 32'(last_re_cyc - n_addr), 32'(1));
    chk("t2_tx_latency", 32'(last_txv_cyc - last_re_cyc), 32'(2));
    chk("t2_tx_byte", 32'(last_tx), 32'(8'h3C));

    // 3: bad opcode, then out-of-range address
    err0 = err_cnt; we0 = we_cnt + re_cnt;
    tick(1'b1, 8'h42, 1'b0);
    tick(1'b1, 8'hAA, 1'b0);
    tick(1'b1, 8'h20, 1'b0);
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    chk("t3_errors", 32'(err_cnt - err0), 32'(2));
    chk("t3_no_strobe", 32'(we_cnt + re_cnt - we0), 32'(0));

    // 4: read while TX busy for 10 cycles, with a stray byte in the wait
    err0 = err_cnt; txv0 = txv_cnt;
    tick(1'b1, 8'hBB, 1'b0);
    tick(1'b1, 8'h05, 1'b1);
    for (int k = 0; k < 10; k++) tick(k == 4, 8'h77, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    fall_cyc = cyc;
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    chk("t4_tx_after_fall", 32'(last_txv_cyc - fall_cyc), 32'(1));
    chk("t4_tx_count", 32'(txv_cnt - txv0), 32'(1));
    chk("t4_drop_error", 32'(err_cnt - err0), 32'(1));

    // 5: reset mid-frame discards the partial write
    tick(1'b1, 8'hAA, 1'b0);
    tick(1'b1, 8'h05, 1'b0);
    do_reset(2);
    err0 = err_cnt; we0 = we_cnt;
    tick(1'b1, 8'h3C, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    chk("t5_bad_opcode", 32'(err_cnt - err0), 32'(1));
    chk("t5_no_write", 32'(we_cnt - we0), 32'(0));

    // 6: back-to-back write then read of address 0
    tick(1'b1, 8'hAA, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'hBB, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    chk("t6_tx_byte", 32'(last_tx), 32'(8'h11));

    // Randomized traffic, including stray read-valid pulses
    spur_en = 1'b1;
    busy_r  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) busy_r = !busy_r;
      if ($urandom_range(0, 1) == 1) tick(1'b1, pick_byte(), busy_r);
      else                           tick(1'b0, 8'h00, busy_r);
    end
    spur_en = 1'b0;
    repeat (20) tick(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_reg_file_cmd_ctrl
